// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default parameter values and a small width helper.
package uart_tx_arbiter_pkg;

    // FSM encoding, kept as plain constants so older tools can read it too
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    // Default configuration: two producers, three-byte frames, fixed priority
    localparam int DEFAULT_NUM_CH      = 2;
    localparam int DEFAULT_FRAME_BYTES = 3;
    localparam int DEFAULT_RR_MODE     = 0;
    localparam int DEFAULT_TIMEOUT     = 4095;

    // Bits needed to index n items, never less than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational winner selection: scans requests starting just after the
// pointer and wrapping. With the pointer fixed at NUM_CH-1 the scan starts at
// channel 0, which gives plain lowest-index priority.
module rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int PTR_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] win_o,
    output logic [PTR_W-1:0]  win_idx_o,
    output logic              any_o
);

    int  cand;
    logic found;

    // First requester strictly after the pointer wins
    always_comb begin
        win_o     = '0;
        win_idx_o = '0;
        cand      = 0;
        found     = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = (int'(ptr_i) + k) % NUM_CH;
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                win_o[cand]     = 1'b1;
                win_idx_o       = PTR_W'(cand);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic transmit arbiter in front of the UART byte input. A whole frame
// is captured from the winning producer, then paced out one byte per UART
// ready pulse. A per-byte watchdog abandons frames whose UART never answers.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_CH      = DEFAULT_NUM_CH,
    parameter int FRAME_BYTES = DEFAULT_FRAME_BYTES,
    parameter int RR_MODE     = DEFAULT_RR_MODE,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CH-1:0]               ch_en,
    input  logic [NUM_CH-1:0]               ch_valid,
    input  logic [NUM_CH*FRAME_BYTES*8-1:0] ch_frame,
    output logic [NUM_CH-1:0]               ch_ack,
    output logic [7:0]                      dataIn_bits,
    input  logic                            dataIn_ready,
    output logic [NUM_CH-1:0]               grant,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            timeout_err
);

    localparam int FW    = FRAME_BYTES * 8;
    localparam int IDX_W = idx_width(FRAME_BYTES);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int PTR_W = idx_width(NUM_CH);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_CH - 1);

    logic [1:0]        state_q, state_d;
    logic [FW-1:0]     buf_q, buf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] win;
    logic [PTR_W-1:0]  win_idx;
    logic              win_any;
    logic [PTR_W-1:0]  pick_ptr;
    logic [FW-1:0]     sel_frame;

    assign req = ch_valid & ch_en;

    // Round-robin follows the last grant; priority mode always scans from 0
    generate
        if (RR_MODE != 0) begin : g_rr_ptr
            assign pick_ptr = ptr_q;
        end else begin : g_prio_ptr
            assign pick_ptr = PTR_INIT;
        end
    endgenerate

    rr_picker #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_picker (
        .req_i     (req),
        .ptr_i     (pick_ptr),
        .win_o     (win),
        .win_idx_o (win_idx),
        .any_o     (win_any)
    );

    // One-hot mux of the winning channel's frame
    always_comb begin
        sel_frame = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (win[c]) begin
                sel_frame = sel_frame | ch_frame[c*FW +: FW];
            end
        end
    end

    // Next-state logic: grant and capture, byte pacing, watchdog abort
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        ack_d   = '0;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_SEND;
                    buf_d   = sel_frame;
                    ack_d   = win;
                    grant_d = win;
                    idx_d   = '0;
                    wd_d    = '0;
                    if (RR_MODE != 0) begin
                        ptr_d = win_idx;
                    end
                end
            end
            ST_SEND: begin
                if (dataIn_ready) begin
                    wd_d = '0;
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    // Byte stalled for TIMEOUT cycles: drop the rest of the frame
                    state_d = ST_ABORT;
                    grant_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously so a reset kills any partial frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            wd_q    <= '0;
            ptr_q   <= PTR_INIT;
            grant_q <= '0;
            ack_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dataIn_bits = buf_q[{idx_q, 3'b000} +: 8];
    assign ch_ack      = ack_q;
    assign grant       = grant_q;
    assign busy        = (state_q == ST_SEND);
    assign frame_done  = done_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter. Two instances run side by
// side: fixed priority and round-robin. The reference model derives the
// service order of each round from the arbitration rules and queues the
// expected channel/byte stream; a negedge monitor pops and compares.
module tb_uart_tx_arbiter;

    localparam int NCH = 3;
    localparam int FB  = 3;
    localparam int TMO = 10;
    localparam int FBW = FB * 8;
    localparam int FW  = NCH * FBW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input int inst, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL inst%0d %s: got 0x%0h, required 0x%0h", inst, name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic           rst;
        logic           ready;
        logic           busy;
        logic           done;
        logic           err;
        logic [7:0]     bits;
        logic [NCH-1:0] en;
        logic [NCH-1:0] valid;
        logic [NCH-1:0] ack;
        logic [NCH-1:0] grant;
        logic [FW-1:0]  frame;
        logic [FW-1:0]  scr;

        // Producer state: frames queued per channel and how many were acked
        logic [FBW-1:0] pend [NCH][8];
        int             pend_n [NCH];
        int             prod_rd [NCH];

        // Scoreboard
        int             exp_ch_q [$];
        logic [7:0]     exp_byte_q [$];
        logic [NCH-1:0] cur_g;
        int             nbytes;
        int             done_cnt;
        int             last;
        int             ewin;
        bit             fin;

        uart_tx_arbiter #(
            .NUM_CH      (NCH),
            .FRAME_BYTES (FB),
            .RR_MODE     (gi),
            .TIMEOUT     (TMO)
        ) dut (
            .clock        (clk),
            .reset        (rst),
            .ch_en        (en),
            .ch_valid     (valid),
            .ch_frame     (frame),
            .ch_ack       (ack),
            .dataIn_bits  (bits),
            .dataIn_ready (ready),
            .grant        (grant),
            .busy         (busy),
            .frame_done   (done),
            .timeout_err  (err)
        );

        // A channel presents its next queued frame until all are acked
        always_comb begin
            valid = '0;
            frame = scr;
            for (int c = 0; c < NCH; c++) begin
                if (prod_rd[c] < pend_n[c]) begin
                    valid[c] = 1'b1;
                    frame[c*FBW +: FBW] = pend[c][prod_rd[c] % 8] ^ scr[c*FBW +: FBW];
                end
            end
        end

        // Reference model: service order of the currently pending frames
        task automatic model_round();
            int left [NCH];
            int rd [NCH];
            int w;
            for (int c = 0; c < NCH; c++) begin
                left[c] = en[c] ? (pend_n[c] - prod_rd[c]) : 0;
                rd[c]   = prod_rd[c];
            end
            w = 0;
            while (w >= 0) begin
                w = -1;
                for (int k = 1; k <= NCH; k++) begin
                    int c;
                    c = (gi == 1) ? ((last + k) % NCH) : (k - 1);
                    if (w < 0 && left[c] > 0) w = c;
                end
                if (w >= 0) begin
                    exp_ch_q.push_back(w);
                    for (int b = 0; b < FB; b++) exp_byte_q.push_back(pend[w][rd[w]][b*8 +: 8]);
                    rd[w]++;
                    left[w]--;
                    last = w;
                end
            end
        endtask

        task automatic check_idle_outputs(input string tag);
            check(gi, {tag, "_bits"},  32'(bits),  32'h0);
            check(gi, {tag, "_grant"}, 32'(grant), 32'h0);
            check(gi, {tag, "_busy"},  32'(busy),  32'h0);
            check(gi, {tag, "_ack"},   32'(ack),   32'h0);
            check(gi, {tag, "_done"},  32'(done),  32'h0);
            check(gi, {tag, "_err"},   32'(err),   32'h0);
        endtask

        task automatic load_single(input int ch);
            @(posedge clk); #1;
            ready = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                prod_rd[c] = 0;
                pend_n[c]  = (c == ch) ? 1 : 0;
            end
            pend[ch][0] = FBW'($urandom);
            en = '1;
            model_round();
        endtask

        task automatic wait_grant();
            int cyc;
            cyc = 0;
            while (grant == '0 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            check(gi, "grant_within_bound", 32'(cyc < 20), 32'h1);
        endtask

        // mode 0: random frames/enables; mode 1: single fixed ch0 frame,
        // then scramble its ch_frame and disable it once acked
        task automatic run_round(input int mode);
            int cyc;
            int gap;
            @(posedge clk); #1;
            ready = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                prod_rd[c] = 0;
                pend_n[c]  = (mode == 1) ? ((c == 0) ? 1 : 0) : int'($urandom_range(0, 3));
                for (int k = 0; k < 8; k++) pend[c][k] = FBW'($urandom);
            end
            if (mode == 1) begin
                pend[0][0] = 24'h031281;
                en = '1;
            end else if ($urandom_range(0, 1) == 1) begin
                en = '1;
            end else begin
                en = NCH'($urandom_range(1, (1 << NCH) - 1));
            end
            model_round();
            cyc = 0;
            while ((exp_ch_q.size() != 0 || busy) && cyc < 3000) begin
                gap = $urandom_range(0, 3);
                ready = 1'b0;
                repeat (gap) begin
                    @(posedge clk); #1;
                    cyc++;
                end
                ready = 1'b1;
                @(posedge clk); #1;
                cyc++;
                ready = 1'b0;
                if (mode == 1 && prod_rd[0] == 1 && scr == '0) begin
                    scr[FBW-1:0] = FBW'($urandom) | FBW'(1);
                    en[0] = 1'b0;
                end
            end
            ready = 1'b0;
            check(gi, "round_drained", 32'(cyc < 3000), 32'h1);
            check(gi, "bytes_left", 32'(exp_byte_q.size()), 32'h0);
            scr = '0;
            for (int c = 0; c < NCH; c++) pend_n[c] = prod_rd[c];
        endtask

        // One accepted byte, then silence until the watchdog fires
        task automatic run_timeout();
            int d0;
            load_single(1);
            wait_grant();
            check(gi, "timeout_grant", 32'(grant), 32'h2);
            d0 = done_cnt;
            ready = 1'b1;
            @(posedge clk); #1;
            ready = 1'b0;
            repeat (TMO) @(posedge clk);
            #1;
            check(gi, "err_before_abort", 32'(err), 32'h0);
            check(gi, "busy_before_abort", 32'(busy), 32'h1);
            @(posedge clk); #1;
            check(gi, "err_after_abort", 32'(err), 32'h1);
            check(gi, "grant_after_abort", 32'(grant), 32'h0);
            check(gi, "busy_after_abort", 32'(busy), 32'h0);
            @(posedge clk); #1;
            check(gi, "no_done_on_abort", 32'(done_cnt - d0), 32'h0);
            exp_byte_q.delete();
        endtask

        // Two bytes out, then an asynchronous reset in the middle of a cycle
        task automatic run_reset_mid();
            load_single(2);
            wait_grant();
            check(gi, "reset_test_grant", 32'(grant), 32'h4);
            ready = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            ready = 1'b0;
            check(gi, "third_byte_pending", 32'(exp_byte_q.size()), 32'h1);
            if (exp_byte_q.size() == 1) check(gi, "third_byte_value", 32'(bits), 32'(exp_byte_q[0]));
            #2;
            rst = 1'b1;
            #1;
            check_idle_outputs("async_reset");
            exp_ch_q.delete();
            exp_byte_q.delete();
            last = NCH - 1;
            for (int c = 0; c < NCH; c++) pend_n[c] = prod_rd[c];
            @(posedge clk); #1;
            rst = 1'b0;
        endtask

        initial begin : main
            rst = 1'b1;
            ready = 1'b0;
            en = '0;
            scr = '0;
            last = NCH - 1;
            nbytes = 0;
            done_cnt = 0;
            cur_g = '0;
            repeat (3) @(posedge clk);
            #1;
            check_idle_outputs("reset_state");
            rst = 1'b0;
            run_round(1);
            for (int r = 0; r < 12; r++) run_round(0);
            run_timeout();
            run_round(0);
            run_reset_mid();
            run_round(0);
            fin = 1'b1;
        end

        // Monitor: compare grants and accepted bytes; producers advance on ack
        always @(negedge clk) begin
            if (rst == 1'b0) begin
                if (ack != '0) begin
                    check(gi, "ack_expected", 32'(exp_ch_q.size() != 0), 32'h1);
                    if (exp_ch_q.size() != 0) begin
                        ewin = exp_ch_q.pop_front();
                        cur_g = NCH'(1 << ewin);
                        check(gi, "ack_onehot", 32'(ack), 32'(cur_g));
                        check(gi, "grant_at_ack", 32'(grant), 32'(cur_g));
                        if (exp_byte_q.size() != 0) check(gi, "byte0_at_grant", 32'(bits), 32'(exp_byte_q[0]));
                        $display("inst%0d: frame granted to ch%0d", gi, ewin);
                    end
                    nbytes = 0;
                    for (int c = 0; c < NCH; c++) if (ack[c]) prod_rd[c]++;
                end
                if (ready && busy) begin
                    check(gi, "grant_hold", 32'(grant), 32'(cur_g));
                    check(gi, "byte_expected", 32'(exp_byte_q.size() != 0), 32'h1);
                    if (exp_byte_q.size() != 0) check(gi, "byte_value", 32'(bits), 32'(exp_byte_q.pop_front()));
                    nbytes++;
                end
                if (done) begin
                    check(gi, "bytes_per_frame", 32'(nbytes), 32'(FB));
                    check(gi, "busy_at_done", 32'(busy), 32'h0);
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        wait (g_inst[0].fin && g_inst[1].fin);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL global_time_limit: got still running, required finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
